barker_correlator: RTL and testbench



---
 rtl/barker_pkg.sv | 18 +
 rtl/axis_1bit.sv | 12 +
 rtl/barker_match_core.sv | 65 ++++++
 rtl/barker_correlator.sv | 74 +++++++
 tb/tb_barker_correlator.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/barker_pkg.sv
// rtl/barker_pkg.sv - Barker-13 code constant and popcount helper shared by the correlator
package barker_pkg;

  localparam int BARKER_LEN = 13;

  // Bit k holds chip c[k] in transmit order (c[0] is sent first).
  localparam logic [BARKER_LEN-1:0] BARKER13 = 13'b1010110011111;

  function automatic logic [3:0] popcount13(input logic [BARKER_LEN-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int k = 0; k < BARKER_LEN; k++) begin
      n = n + {3'b000, v[k]};
    end
    return n;
  endfunction

endpackage

// File: rtl/axis_1bit.sv
// rtl/axis_1bit.sv - single-bit AXI-Stream style channel with master/slave views
interface axis_1bit;

  logic tdata;
  logic tvalid;
  logic tlast;
  logic tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/barker_match_core.sv
// rtl/barker_match_core.sv - 13-chip window, agreement count and threshold compare
module barker_match_core
  import barker_pkg::*;
#(
  parameter int ARCH_TYPE = 0,
  parameter int THRESHOLD = 13
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic adv_i,
  input  logic shift_i,
  input  logic chip_i,
  output logic detect_o
);

  localparam logic [3:0] THR = 4'(THRESHOLD);

  logic [BARKER_LEN-1:0] win_q;
  logic [BARKER_LEN-1:0] win_d;

  // Newest chip enters at the top so bit 0 is the oldest and lines up with c[0].
  assign win_d = shift_i ? {chip_i, win_q[BARKER_LEN-1:1]} : win_q;

  if (ARCH_TYPE == 0) begin : g_single
    logic det_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        win_q <= '0;
        det_q <= 1'b0;
      end else if (adv_i && shift_i) begin
        win_q <= win_d;
        det_q <= popcount13(~(win_d ^ BARKER13)) >= THR;
      end
    end

    assign detect_o = det_q;
  end else begin : g_pipe
    logic [BARKER_LEN-1:0] agree_q;
    logic [3:0]            sum_lo_q;
    logic [3:0]            sum_hi_q;
    logic                  det_q;

    // Stages move together on advance; bubbles carry stale data that the
    // valid pipeline in the wrapper masks off.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        win_q    <= '0;
        agree_q  <= '0;
        sum_lo_q <= '0;
        sum_hi_q <= '0;
        det_q    <= 1'b0;
      end else if (adv_i) begin
        win_q    <= win_d;
        agree_q  <= ~(win_d ^ BARKER13);
        sum_lo_q <= popcount13({6'b000000, agree_q[6:0]});
        sum_hi_q <= popcount13({agree_q[12:7], 7'b0000000});
        det_q    <= (sum_lo_q + sum_hi_q) >= THR;
      end
    end

    assign detect_o = det_q;
  end

endmodule

// File: rtl/barker_correlator.sv
// rtl/barker_correlator.sv - streaming Barker-13 detector, one detect beat per accepted chip
module barker_correlator
  import barker_pkg::*;
#(
  parameter int ARCH_TYPE = 0,
  parameter int THRESHOLD = 13
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic s_axis_tdata,
  input  logic s_axis_tvalid,
  input  logic s_axis_tlast,
  output logic s_axis_tready,
  output logic m_axis_tdata,
  output logic m_axis_tvalid,
  output logic m_axis_tlast,
  input  logic m_axis_tready
);

  localparam int LAT = (ARCH_TYPE == 0) ? 1 : 3;

  axis_1bit s_if ();
  axis_1bit m_if ();

  logic           advance;
  logic           s_fire;
  logic [LAT-1:0] vld_q;
  logic [LAT-1:0] last_q;

  assign s_if.tdata    = s_axis_tdata;
  assign s_if.tvalid   = s_axis_tvalid;
  assign s_if.tlast    = s_axis_tlast;
  assign s_axis_tready = s_if.tready;

  assign m_if.tready   = m_axis_tready;
  assign m_axis_tdata  = m_if.tdata;
  assign m_axis_tvalid = m_if.tvalid;
  assign m_axis_tlast  = m_if.tlast;

  // The whole pipe freezes only while a finished beat waits on the consumer.
  assign advance     = !m_if.tvalid || m_if.tready;
  assign s_if.tready = advance && !i_rst;
  assign s_fire      = s_if.tvalid && s_if.tready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q  <= '0;
      last_q <= '0;
    end else if (advance) begin
      vld_q[0]  <= s_fire;
      last_q[0] <= s_if.tlast;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
      end
    end
  end

  barker_match_core #(
    .ARCH_TYPE (ARCH_TYPE),
    .THRESHOLD (THRESHOLD)
  ) u_core (
    .clk_i    (i_clk),
    .rst_i    (i_rst),
    .adv_i    (advance),
    .shift_i  (s_fire),
    .chip_i   (s_if.tdata),
    .detect_o (m_if.tdata)
  );

  assign m_if.tvalid = vld_q[LAT-1];
  assign m_if.tlast  = last_q[LAT-1];

endmodule

// File: tb/tb_barker_correlator.sv
// tb/tb_barker_correlator.sv - directed and scoreboarded bench over both architectures and thresholds
`timescale 1ns/1ps
module tb_barker_correlator;

  localparam int N_DUT  = 4;
  localparam int N_FEED = 21;
  localparam bit CODE_TX [13] = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 0, 1, 0, 1};

  logic clk = 1'b0;
  logic rst;
  logic s_tdata;
  logic s_tvalid;
  logic s_tlast;
  logic m_tready;
  wire [N_DUT-1:0] s_tready;
  wire [N_DUT-1:0] m_tdata;
  wire [N_DUT-1:0] m_tvalid;
  wire [N_DUT-1:0] m_tlast;

  int checks = 0;
  int errors = 0;

  logic dir_det  [N_DUT][64];
  logic dir_last [N_DUT][64];
  int   dir_cyc  [N_DUT][64];
  int   nbeat    [N_DUT];
  int   acc_cyc  [64];
  int   nacc;
  logic [31:0] ref_vec [N_DUT];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Instances 0/1: THRESHOLD 13, instances 2/3: THRESHOLD 12; even = ARCH 0, odd = ARCH 1.
  for (genvar k = 0; k < N_DUT; k++) begin : g_dut
    localparam int ARCH = k % 2;
    localparam int THR  = (k < 2) ? 13 : 12;

    barker_correlator #(
      .ARCH_TYPE (ARCH),
      .THRESHOLD (THR)
    ) u_dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tlast  (s_tlast),
      .s_axis_tready (s_tready[k]),
      .m_axis_tdata  (m_tdata[k]),
      .m_axis_tvalid (m_tvalid[k]),
      .m_axis_tlast  (m_tlast[k]),
      .m_axis_tready (m_tready)
    );

    logic [12:0] mw = '0;
    logic [1:0]  exp_q [$];
    logic        stall_q = 1'b0;
    logic        held_data = 1'b0;
    logic        held_last = 1'b0;

    always @(negedge clk) begin : test_mon
      int n;
      logic [1:0] e;
      if (rst) begin
        mw = '0;
        exp_q.delete();
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          check($sformatf("hold_valid[%0d]", k), m_tvalid[k], 1);
          check($sformatf("hold_data[%0d]", k), m_tdata[k], held_data);
          check($sformatf("hold_last[%0d]", k), m_tlast[k], held_last);
        end
        if (m_tvalid[k] && m_tready) begin
          if (exp_q.size() == 0) begin
            check($sformatf("sb_extra_beat[%0d]", k), 1, 0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("sb_data[%0d]", k), m_tdata[k], e[1]);
            check($sformatf("sb_last[%0d]", k), m_tlast[k], e[0]);
          end
        end
        if (s_tvalid && s_tready[k]) begin
          mw = {s_tdata, mw[12:1]};
          n = 0;
          for (int i = 0; i < 13; i++) if (mw[i] == CODE_TX[i]) n++;
          exp_q.push_back({(n >= THR), s_tlast});
        end
        stall_q   = m_tvalid[k] && !m_tready;
        held_data = m_tdata[k];
        held_last = m_tlast[k];
      end
    end
  end

  function automatic logic [12:0] tx(input string s);
    logic [12:0] v;
    for (int i = 0; i < 13; i++) v[i] = (s[i] == "1");
    return v;
  endfunction

  function automatic int lat_of(input int k);
    return (k % 2 == 1) ? 3 : 1;
  endfunction

  function automatic int ones(input int k);
    int n;
    n = 0;
    for (int b = 0; b < nbeat[k] && b < 64; b++) if (dir_det[k][b]) n++;
    return n;
  endfunction

  function automatic int last_count(input int k);
    int n;
    n = 0;
    for (int b = 0; b < nbeat[k] && b < 64; b++) if (dir_last[k][b]) n++;
    return n;
  endfunction

  function automatic logic [31:0] det_vec(input int k);
    logic [31:0] v;
    v = '0;
    for (int b = 0; b < N_FEED; b++) v[b] = dir_det[k][b];
    return v;
  endfunction

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      for (int k = 0; k < N_DUT; k++) begin
        check($sformatf("rst_s_tready[%0d]", k), s_tready[k], 0);
        if (i > 0) begin
          check($sformatf("rst_m_tvalid[%0d]", k), m_tvalid[k], 0);
          check($sformatf("rst_m_tdata[%0d]", k), m_tdata[k], 0);
          check($sformatf("rst_m_tlast[%0d]", k), m_tlast[k], 0);
        end
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < N_DUT; k++) check($sformatf("post_rst_s_tready[%0d]", k), s_tready[k], 1);
  endtask

  // 13 pattern chips then zeros; optional tlast position and output stall window.
  task automatic run_seq(input logic [12:0] seq, input int last_idx, input int stall_at, input int stall_len);
    int idx;
    int it;
    bit done;
    idx = 0;
    it = 0;
    nacc = 0;
    for (int k = 0; k < N_DUT; k++) nbeat[k] = 0;
    done = 1'b0;
    while (!done && it < 80) begin
      @(posedge clk);
      #1;
      m_tready = !(stall_len > 0 && it >= stall_at && it < stall_at + stall_len);
      s_tvalid = (idx < N_FEED);
      s_tdata  = (idx < 13) ? seq[idx] : 1'b0;
      s_tlast  = (idx == last_idx);
      @(negedge clk);
      for (int k = 0; k < N_DUT; k++) begin
        if (m_tvalid[k] && m_tready && nbeat[k] < 64) begin
          dir_det[k][nbeat[k]]  = m_tdata[k];
          dir_last[k][nbeat[k]] = m_tlast[k];
          dir_cyc[k][nbeat[k]]  = it;
          nbeat[k]++;
        end
      end
      if (s_tvalid && s_tready[0] && nacc < 64) begin
        acc_cyc[nacc] = it;
        nacc++;
        idx++;
      end
      it++;
      done = (idx >= N_FEED);
      for (int k = 0; k < N_DUT; k++) if (nbeat[k] < N_FEED) done = 1'b0;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    check("dir_accepted", nacc, N_FEED);
  endtask

  initial begin
    int acc0;
    int cycles;
    int ptr;
    rst = 1'b1;
    s_tdata = 1'b0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    m_tready = 1'b1;

    apply_reset();
    run_seq(tx("1111100110101"), -1, 0, 0);
    for (int k = 0; k < N_DUT; k++) begin
      check($sformatf("exact_beats[%0d]", k), nbeat[k], N_FEED);
      check($sformatf("exact_det12[%0d]", k), dir_det[k][12], 1);
      check($sformatf("exact_latency[%0d]", k), dir_cyc[k][12] - acc_cyc[12], lat_of(k));
      if (k < 2) check($sformatf("exact_ones[%0d]", k), ones(k), 1);
      ref_vec[k] = det_vec(k);
    end

    apply_reset();
    run_seq(tx("0000011001010"), -1, 0, 0);
    for (int k = 0; k < 2; k++) check($sformatf("inverted_ones[%0d]", k), ones(k), 0);

    apply_reset();
    run_seq(tx("1111101110101"), -1, 0, 0);
    for (int k = 0; k < N_DUT; k++)
      check($sformatf("flip6_det12[%0d]", k), dir_det[k][12], (k >= 2) ? 1 : 0);

    apply_reset();
    run_seq(tx("1111100110101"), 9, 8, 5);
    for (int k = 0; k < N_DUT; k++) begin
      check($sformatf("bp_beats[%0d]", k), nbeat[k], N_FEED);
      check($sformatf("bp_det_seq[%0d]", k), det_vec(k), ref_vec[k]);
      check($sformatf("bp_last9[%0d]", k), dir_last[k][9], 1);
      check($sformatf("bp_last_count[%0d]", k), last_count(k), 1);
    end

    apply_reset();
    acc0 = 0;
    cycles = 0;
    ptr = 0;
    while (acc0 < 8192 && cycles < 60000) begin
      @(posedge clk);
      #1;
      rst      = (cycles == 3000 || cycles == 3001);
      s_tvalid = ($urandom_range(3) != 0);
      s_tdata  = CODE_TX[ptr] ^ ($urandom_range(15) == 0);
      s_tlast  = ($urandom_range(15) == 0);
      m_tready = ($urandom_range(3) != 0);
      @(negedge clk);
      if (s_tvalid && s_tready[0]) begin
        acc0++;
        ptr = (ptr == 12) ? 0 : ptr + 1;
      end
      cycles++;
    end
    check("rand_chip_budget", (acc0 >= 8192) ? 1 : 0, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (8) @(negedge clk);
    check("rand_drain[0]", g_dut[0].exp_q.size(), 0);
    check("rand_drain[1]", g_dut[1].exp_q.size(), 0);
    check("rand_drain[2]", g_dut[2].exp_q.size(), 0);
    check("rand_drain[3]", g_dut[3].exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
